instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly downstream of the program counter. Latches the current PC address, runs a request/acknowledge read on instruction memory, holds the returned word in an instruction register, and presents it to decode with a valid/ready handshake. Flush discards any in-flight or held instruction after a PC redirect.

## Interface

Parameters:
- WORD_SIZE, 16, instruction and memory data width
- MEM_ADDR_SIZE, 8, instruction memory address width; matches the program counter output
- TIMEOUT_CYCLES, 15, maximum REQ/DROP cycles before a fetch error; used only when FETCH_TIMEOUT_EN is defined

Ports (one clock; reset is asynchronous and active-low):
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- pc  input  MEM_ADDR_SIZE  current program counter value
- fetch_enable  input  1  core requests the instruction at pc
- flush  input  1  PC redirected; discard in-flight and held instruction
- mem_req  output  1  read request to instruction memory
- mem_addr  output  MEM_ADDR_SIZE  read address, stable while mem_req high
- mem_ack  input  1  single-cycle completion strobe; mem_rdata valid in the same cycle
- mem_rdata  input  WORD_SIZE  read data
- instr  output  WORD_SIZE  held instruction word
- instr_addr  output  MEM_ADDR_SIZE  address instr was fetched from
- instr_valid  output  1  instr/instr_addr valid for decode
- instr_ready  input  1  decode accepts instr this cycle
- busy  output  1  high in any state other than IDLE
- fetch_error  output  1  sticky memory timeout flag

## Operation

- States: IDLE, REQ, DROP, HOLD, ERROR (ERROR exists only with FETCH_TIMEOUT_EN).
- IDLE: on fetch_enable && !flush, latch pc into mem_addr and go to REQ.
- REQ: mem_req=1. On mem_ack: capture mem_rdata into instr and mem_addr into instr_addr, then go to HOLD. On flush without mem_ack: go to DROP. On flush with mem_ack: discard data and go to IDLE.
- DROP: mem_req=0. Wait for the outstanding mem_ack, discard the data, then go to IDLE. Flush is ignored here.
- HOLD: instr_valid=1; instr and instr_addr stay stable. flush: clear valid and go to IDLE. On instr_ready && !flush: go to REQ with pc latched if fetch_enable is high, otherwise go to IDLE.
- In a flush cycle, fetch_enable is ignored in every state.
- mem_ack outside REQ/DROP is ignored. instr_ready outside HOLD is ignored.
- mem_addr changes only on entry to REQ.

## Timing

- Reset (async assert, sync release): state=IDLE. mem_req, instr_valid, busy and fetch_error are 0. mem_addr, instr and instr_addr are 0.
- Reset mid-transaction aborts immediately. Any late mem_ack after reset is ignored.
- fetch_enable sampled at edge N: mem_req is high after N.
- mem_ack at edge N+k (k≥1): instr_valid is high after N+k.
- Zero-wait memory gives a minimum fetch-to-valid latency of 2 edges.
- Back-to-back (fetch_enable held, instr_ready held, ack in the first REQ cycle): one instruction per 2 cycles.
- All outputs are registered except busy, which is decoded from state.

## Configuration

- FETCH_TIMEOUT_EN defined:
  - A cycle counter runs in REQ/DROP and clears on entry to either state.
  - If the counter reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, set fetch_error, enter ERROR.
  - ERROR ignores all inputs; it is left only by reset_n.
- FETCH_TIMEOUT_EN undefined:
  - No counter.
  - fetch_error is tied to 0 and ERROR is absent.
  - REQ/DROP wait indefinitely.

## Test plan

- Reset, then pc=0x05, fetch_enable pulse, mem_ack on the first REQ cycle with mem_rdata=0xA1B2 -> after 2 edges instr_valid=1, instr=0xA1B2, instr_addr=0x05. Hold instr_ready=0 for 3 cycles -> outputs stable.
- pc=0x10, mem_ack delayed 4 cycles -> mem_req high and mem_addr=0x10 for all 4 cycles, then HOLD with the correct data.
- flush in the second REQ cycle, mem_ack 2 cycles later with 0xDEAD -> DROP, instr_valid never rises, returns to IDLE, busy=0.
- flush in the same cycle as mem_ack -> data discarded, IDLE next cycle. flush while in HOLD -> instr_valid=0 next cycle.
- fetch_enable and instr_ready held high, zero-wait memory, pc stepping 0,1,2 -> 3 instructions delivered in 6 cycles with matching instr_addr.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=15 and no mem_ack -> fetch_error=1 and mem_req=0 after 15 REQ cycles. State stays in ERROR despite fetch_enable. reset_n low clears fetch_error.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side valid/ready handoff.
// master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_if #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
);
  logic                     mem_req;
  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic                     mem_ack;
  logic [WORD_SIZE-1:0]     mem_rdata;
  logic [WORD_SIZE-1:0]     instr;
  logic [MEM_ADDR_SIZE-1:0] instr_addr;
  logic                     instr_valid;
  logic                     instr_ready;

  modport master (
    output mem_req, mem_addr, instr, instr_addr, instr_valid,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_addr, instr_valid,
    output mem_ack, mem_rdata, instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC latch, req/ack memory read, held instruction to decode; 2-edge min latency, holds until instr_ready.
// Optional FETCH_TIMEOUT_EN macro adds a REQ/DROP timeout that parks the unit in a sticky ERROR state.
module instruction_fetch #(
  parameter int WORD_SIZE      = 16,
  parameter int MEM_ADDR_SIZE  = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [MEM_ADDR_SIZE-1:0] pc,
  input  logic                     fetch_enable,
  input  logic                     flush,
  instruction_fetch_if.master      bus,
  output logic                     busy,
  output logic                     fetch_error
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DROP, S_HOLD, S_ERROR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HOLD} state_t;
`endif

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_load_addr;
  logic                     w_capture;

  logic                     r_mem_req;
  logic [MEM_ADDR_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0]     r_instr;
  logic [MEM_ADDR_SIZE-1:0] r_instr_addr;
  logic                     r_instr_valid;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic          r_fetch_error;

  // Counter restarts whenever the FSM changes state, so REQ->DROP starts a fresh window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_DROP) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_fetch_error <= 1'b0;
    else          r_fetch_error <= (w_next == S_ERROR);
  end

  assign fetch_error = r_fetch_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign fetch_error      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_addr = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fetch_enable && !flush) begin
          w_load_addr = 1'b1;
          w_next      = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          if (flush) begin
            w_next = S_IDLE;
          end else begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
          end
        end else if (flush) begin
          w_next = S_DROP;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_timeout) begin
          w_next = S_ERROR;
        end
`endif
      end
      S_DROP: begin
        if (bus.mem_ack) begin
          w_next = S_IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (w_timeout) begin
          w_next = S_ERROR;
        end
`endif
      end
      S_HOLD: begin
        if (flush) begin
          w_next = S_IDLE;
        end else if (bus.instr_ready) begin
          if (fetch_enable) begin
            w_load_addr = 1'b1;
            w_next      = S_REQ;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = r_state;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= '0;
      r_instr_addr  <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_mem_req     <= (w_next == S_REQ);
      r_instr_valid <= (w_next == S_HOLD);
      if (w_load_addr) r_mem_addr <= pc;
      if (w_capture) begin
        r_instr      <= bus.mem_rdata;
        r_instr_addr <= r_mem_addr;
      end
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_addr  = r_instr_addr;
  assign bus.instr_valid = r_instr_valid;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: hand-computed expectations for fetch, wait states, flush, back-to-back and timeout.
module tb_instruction_fetch;
  logic       clock;
  logic       reset_n;
  logic [7:0] pc;
  logic       fetch_enable;
  logic       flush;
  logic       busy;
  logic       fetch_error;
  int         n_chk;
  int         n_pass;
  int         k;

  instruction_fetch_if #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) ifc ();

  instruction_fetch #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .TIMEOUT_CYCLES(15)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc           (pc),
    .fetch_enable (fetch_enable),
    .flush        (flush),
    .bus          (ifc),
    .busy         (busy),
    .fetch_error  (fetch_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_pulse(input logic [7:0] addr);
    pc           = addr;
    fetch_enable = 1'b1;
    step();
    fetch_enable = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    reset_n = 1'b0; pc = '0; fetch_enable = 1'b0; flush = 1'b0;
    ifc.mem_ack = 1'b0; ifc.mem_rdata = '0; ifc.instr_ready = 1'b0;

    #3;
    chk("rst_mem_req", ifc.mem_req, 0);
    chk("rst_valid", ifc.instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", fetch_error, 0);
    chk("rst_mem_addr", ifc.mem_addr, 0);
    chk("rst_instr", ifc.instr, 0);
    chk("rst_instr_addr", ifc.instr_addr, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    step();

    // Zero-wait fetch, then hold with decode stalled.
    fetch_pulse(8'h05);
    chk("f1_req", ifc.mem_req, 1);
    chk("f1_addr", ifc.mem_addr, 8'h05);
    chk("f1_busy", busy, 1);
    chk("f1_novalid", ifc.instr_valid, 0);
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'hA1B2;
    step();
    ifc.mem_ack = 1'b0;
    chk("f1_valid", ifc.instr_valid, 1);
    chk("f1_instr", ifc.instr, 16'hA1B2);
    chk("f1_iaddr", ifc.instr_addr, 8'h05);
    chk("f1_req_off", ifc.mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      ifc.mem_rdata = 16'h0BAD;
      step();
      chk("f1_hold_valid", ifc.instr_valid, 1);
      chk("f1_hold_instr", ifc.instr, 16'hA1B2);
      chk("f1_hold_iaddr", ifc.instr_addr, 8'h05);
    end
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    chk("f1_idle_valid", ifc.instr_valid, 0);
    chk("f1_idle_busy", busy, 0);

    // Four wait cycles; pc moves but mem_addr must not.
    fetch_pulse(8'h10);
    pc = 8'h77;
    chk("f2_req0", ifc.mem_req, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("f2_wait_req", ifc.mem_req, 1);
      chk("f2_wait_addr", ifc.mem_addr, 8'h10);
    end
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h1234;
    step();
    ifc.mem_ack = 1'b0;
    chk("f2_valid", ifc.instr_valid, 1);
    chk("f2_instr", ifc.instr, 16'h1234);
    chk("f2_iaddr", ifc.instr_addr, 8'h10);
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;

    // Flush in second REQ cycle -> DROP, late ack discarded.
    fetch_pulse(8'h20);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f3_drop_req", ifc.mem_req, 0);
    chk("f3_drop_busy", busy, 1);
    step();
    chk("f3_drop2_busy", busy, 1);
    chk("f3_drop2_valid", ifc.instr_valid, 0);
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'hDEAD;
    step();
    chk("f3_idle_busy", busy, 0);
    chk("f3_idle_valid", ifc.instr_valid, 0);
    chk("f3_instr_kept", ifc.instr, 16'h1234);
    step();
    ifc.mem_ack = 1'b0;
    chk("f3_stray_ack", busy, 0);
    fetch_enable = 1'b1; flush = 1'b1;
    step();
    fetch_enable = 1'b0; flush = 1'b0;
    chk("f3_fe_flush_idle", busy, 0);

    // Flush together with ack, then flush in HOLD.
    fetch_pulse(8'h30);
    ifc.mem_ack = 1'b1; flush = 1'b1; fetch_enable = 1'b1; ifc.mem_rdata = 16'hBEEF;
    step();
    ifc.mem_ack = 1'b0; flush = 1'b0; fetch_enable = 1'b0;
    chk("f4_ackflush_busy", busy, 0);
    chk("f4_ackflush_valid", ifc.instr_valid, 0);
    chk("f4_ackflush_instr", ifc.instr, 16'h1234);
    fetch_pulse(8'h31);
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h5555;
    step();
    ifc.mem_ack = 1'b0;
    chk("f4_hold_valid", ifc.instr_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("f4_hflush_valid", ifc.instr_valid, 0);
    chk("f4_hflush_busy", busy, 0);

    // Back-to-back with zero-wait memory: 3 instructions in 6 cycles.
    pc = 8'h00; fetch_enable = 1'b1; ifc.instr_ready = 1'b1; k = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ifc.instr_valid) begin
        chk("b2b_instr", ifc.instr, 16'h1000 + k);
        chk("b2b_iaddr", ifc.instr_addr, k);
        k++;
        pc = 8'(k);
        ifc.mem_ack = 1'b0;
      end else begin
        ifc.mem_ack   = ifc.mem_req;
        ifc.mem_rdata = 16'(16'h1000 + ifc.mem_addr);
      end
    end
    chk("b2b_count", k, 3);
    fetch_enable = 1'b0; ifc.mem_ack = 1'b0;
    step();
    ifc.instr_ready = 1'b0;
    chk("b2b_idle", busy, 0);

    // Async reset mid-transaction; late ack afterwards ignored.
    fetch_pulse(8'h50);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req", ifc.mem_req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", ifc.mem_addr, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h9999;
    step();
    ifc.mem_ack = 1'b0;
    chk("ar_late_busy", busy, 0);
    chk("ar_late_valid", ifc.instr_valid, 0);
    chk("ar_late_instr", ifc.instr, 0);

`ifdef FETCH_TIMEOUT_EN
    fetch_pulse(8'h40);
    for (int i = 0; i < 15; i++) begin
      chk("to_req", ifc.mem_req, 1);
      step();
    end
    chk("to_err", fetch_error, 1);
    chk("to_req_off", ifc.mem_req, 0);
    chk("to_busy", busy, 1);
    fetch_enable = 1'b1; ifc.mem_ack = 1'b1; ifc.instr_ready = 1'b1;
    repeat (3) step();
    fetch_enable = 1'b0; ifc.mem_ack = 1'b0; ifc.instr_ready = 1'b0;
    chk("to_stuck_err", fetch_error, 1);
    chk("to_stuck_req", ifc.mem_req, 0);
    chk("to_stuck_valid", ifc.instr_valid, 0);
    reset_n = 1'b0;
    #1;
    chk("to_rst_err", fetch_error, 0);
    chk("to_rst_busy", busy, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
`else
    fetch_pulse(8'h60);
    repeat (20) step();
    chk("nto_req", ifc.mem_req, 1);
    chk("nto_err", fetch_error, 0);
    chk("nto_addr", ifc.mem_addr, 8'h60);
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 16'h0600;
    step();
    ifc.mem_ack = 1'b0;
    chk("nto_valid", ifc.instr_valid, 1);
    chk("nto_instr", ifc.instr, 16'h0600);
    ifc.instr_ready = 1'b1;
    step();
    ifc.instr_ready = 1'b0;
    chk("nto_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
